bus_io_slave: RTL

BUS_IO_SLAVE -- requirements
Module: bus_io_slave

---
 rtl/bus_io_pkg.sv | 20 ++
 rtl/bus_io_mem.sv | 27 ++
 rtl/bus_io_slave.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_io_pkg.sv
// Shared types and constants for the bus I/O slave: bus-cycle states and address width.
package bus_io_pkg;

  localparam int ADDR_W = 20;

  typedef enum logic [2:0] {
    T1  = 3'd0,
    T2  = 3'd1,
    T3R = 3'd2,
    T3W = 3'd3,
    TW  = 3'd4,
    T4  = 3'd5
  } bus_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_io_mem.sv
// Word storage for the bus I/O slave: synchronous write, asynchronous read, no reset.
module bus_io_mem
  import bus_io_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_io_slave.sv
// Bus I/O slave: T1/T2/T3/T4 bus-cycle FSM decoding a window of word storage.
// Optional wait states (TW, wait counter, READY) are built when BUS_IO_WAIT_STATE_EN is defined.
module bus_io_slave
  import bus_io_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h01C00,
  parameter int                DEPTH       = 256,
  parameter logic              IOM_VALID   = 1'b1,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CS,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  output logic              READY
);

  localparam int              IDX_W = idx_width(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(DEPTH);

  bus_state_e        state_q;
  logic [IDX_W-1:0]  index_q;
  logic [IDX_W-1:0]  index_d;
  logic              drive_q;
  logic              hit_s;
  logic              we_s;
  logic [DATA_W-1:0] rdata_s;

  assign hit_s   = CS && ALE && (IOM == IOM_VALID) &&
                   (Address >= BASE_ADDR) && ({1'b0, Address} < LIMIT);
  assign index_d = IDX_W'(Address - BASE_ADDR);
  // A reset at the committing edge must win over the write.
  assign we_s    = (state_q == T3W) && RESET;

`ifdef BUS_IO_WAIT_STATE_EN
  localparam int CNT_W = idx_width(WAIT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;

  // Bus-cycle FSM with wait-state counter; READY and the data-drive enable are registered.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= T1;
      index_q <= '0;
      drive_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        T1: begin
          if (hit_s) begin
            index_q <= index_d;
            state_q <= T2;
          end
        end
        T2: begin
          if (!RD) begin
            state_q <= T3R;
            drive_q <= 1'b1;
            ready_q <= (WAIT_CYCLES == 0);
          end else if (!WR) begin
            state_q <= T3W;
            ready_q <= (WAIT_CYCLES == 0);
          end
        end
        T3R, T3W: begin
          if (WAIT_CYCLES > 0) begin
            state_q <= TW;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
          end else begin
            state_q <= T4;
            drive_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        TW: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= T4;
            cnt_q   <= '0;
            drive_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        T4:      state_q <= T1;
        default: state_q <= T1;
      endcase
    end
  end

  assign READY = ready_q;
`else
  // Bus-cycle FSM without wait states; the data-drive enable is registered.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= T1;
      index_q <= '0;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        T1: begin
          if (hit_s) begin
            index_q <= index_d;
            state_q <= T2;
          end
        end
        T2: begin
          if (!RD) begin
            state_q <= T3R;
            drive_q <= 1'b1;
          end else if (!WR) begin
            state_q <= T3W;
          end
        end
        T3R, T3W: begin
          state_q <= T4;
          drive_q <= 1'b0;
        end
        T4:      state_q <= T1;
        default: state_q <= T1;
      endcase
    end
  end

  assign READY = 1'b1;
`endif

  bus_io_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (we_s),
    .addr_i  (index_q),
    .wdata_i (Data),
    .rdata_o (rdata_s)
  );

  assign Data = drive_q ? rdata_s : {DATA_W{1'bz}};

endmodule
